// File: rtl/svo_tmds_gearbox.sv
`default_nettype none
// ============================================================================
// Module   : svo_tmds_gearbox
// Purpose  : Narrows 10-bit TMDS symbols to OUT_W-bit words (LSB first) for
//            the output serializer, with one symbol of skid buffering and
//            idle-symbol insertion on underflow.
// Revision : 1.0 - initial release
// ============================================================================
module svo_tmds_gearbox #(
   parameter int         OUT_W    = 2,
   parameter logic [9:0] IDLE_SYM = 10'b1101010100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [9:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             out_en,
   output logic [OUT_W-1:0] out_data,
   output logic             out_first,
   output logic             underflow,
   input  logic             underflow_clr
);

   // Words per symbol and phase counter sizing; a single-word symbol keeps a
   // one-bit counter that never leaves zero.
   localparam int c_K  = 10 / OUT_W;
   localparam int c_PW = (c_K > 1) ? $clog2(c_K) : 1;
   localparam logic [c_PW-1:0] c_PLAST = c_PW'(c_K - 1);
   localparam logic [c_PW-1:0] c_PONE  = (c_K == 1) ? '0 : c_PW'(1);

   logic [9:0]       r_h;
   logic             r_hv;
   logic [9:0]       r_s;
   logic [c_PW-1:0]  r_p;
   logic [OUT_W-1:0] r_out_data;
   logic             r_out_first;
   logic             r_underflow;

   logic             w_load;
   logic             w_shift;
   logic             w_xfer;
   logic [9:0]       w_x;

   assign w_load   = out_en && (r_p == '0);
   assign w_shift  = out_en && (r_p != '0);
   assign in_ready = !r_hv || w_load;
   assign w_xfer   = in_valid && in_ready;
   // Symbol to launch at a load: held data, or the idle control symbol.
   assign w_x      = r_hv ? r_h : IDLE_SYM;

   assign out_data  = r_out_data;
   assign out_first = r_out_first;
   assign underflow = r_underflow;

   // Hold-register payload; its contents only matter while r_hv is set.
   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_h <= in_data;
      end
   end

   // Hold valid flag, shift/phase datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hv        <= 1'b0;
         r_s         <= '0;
         r_p         <= '0;
         r_out_data  <= '0;
         r_out_first <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         // A refill in the load cycle keeps the buffer full with new data.
         if (w_xfer) begin
            r_hv <= 1'b1;
         end else if (w_load) begin
            r_hv <= 1'b0;
         end

         if (w_load) begin
            r_out_data  <= w_x[OUT_W-1:0];
            r_s         <= w_x >> OUT_W;
            r_out_first <= 1'b1;
            r_p         <= c_PONE;
         end else if (w_shift) begin
            r_out_data  <= r_s[OUT_W-1:0];
            r_s         <= r_s >> OUT_W;
            r_out_first <= 1'b0;
            r_p         <= (r_p == c_PLAST) ? '0 : r_p + 1'b1;
         end

         // Sticky underflow; a fresh insertion beats a clear in the same cycle.
         if (w_load && !r_hv) begin
            r_underflow <= 1'b1;
         end else if (underflow_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_svo_tmds_gearbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_svo_tmds_gearbox
// Purpose  : Self-checking bench for svo_tmds_gearbox against a symbol-level
//            reference model (pending-symbol queue + word index).
// Revision : 1.0 - initial release
// ============================================================================
module tb_svo_tmds_gearbox;

   localparam int         OUT_W = 2;
   localparam int         K     = 10 / OUT_W;
   localparam logic [9:0] IDLE  = 10'b1101010100;

   logic             clk = 1'b0;
   logic             reset;
   logic [9:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic             out_en;
   logic [OUT_W-1:0] out_data;
   logic             out_first;
   logic             underflow;
   logic             underflow_clr;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state: symbols waiting to be sent, symbol currently
   // being sent and which word of it goes out next.
   logic [9:0]       m_q[$];
   logic [9:0]       m_cur = '0;
   int               m_idx = 0;
   logic [OUT_W-1:0] m_word = '0;
   logic             m_first = 1'b0;
   logic             m_uf = 1'b0;
   logic             s_ready;

   svo_tmds_gearbox #(.OUT_W(OUT_W), .IDLE_SYM(IDLE)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_en        (out_en),
      .out_data      (out_data),
      .out_first     (out_first),
      .underflow     (underflow),
      .underflow_clr (underflow_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
   task automatic step(input logic v, input logic [9:0] d, input logic en,
                       input logic clr, input logic rst);
      logic exp_ready;
      logic xfer;
      logic set_uf;
      in_valid      = v;
      in_data       = d;
      out_en        = en;
      underflow_clr = clr;
      reset         = rst;
      #1;
      exp_ready = (m_q.size() == 0) || (en && m_idx == 0);
      s_ready   = in_ready;
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      xfer = v && exp_ready;
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_idx   = 0;
         m_word  = '0;
         m_first = 1'b0;
         m_uf    = 1'b0;
      end else begin
         set_uf = en && (m_idx == 0) && (m_q.size() == 0);
         if (en) begin
            if (m_idx == 0) begin
               m_cur = (m_q.size() != 0) ? m_q.pop_front() : IDLE;
            end
            m_word  = OUT_W'(m_cur >> (m_idx * OUT_W));
            m_first = (m_idx == 0);
            m_idx   = (m_idx + 1) % K;
         end
         if (xfer) m_q.push_back(d);
         if (set_uf)   m_uf = 1'b1;
         else if (clr) m_uf = 1'b0;
      end
      #1;
      check("out_data",  {{(32-OUT_W){1'b0}}, out_data}, {{(32-OUT_W){1'b0}}, m_word});
      check("out_first", {31'b0, out_first}, {31'b0, m_first});
      check("underflow", {31'b0, underflow}, {31'b0, m_uf});
   endtask

   initial begin
      int nrdy;
      logic [9:0] pat;

      // Reset state.
      step(0, '0, 0, 0, 1);
      step(0, '0, 0, 0, 1);

      // Directed symbol accepted before the first load, then streamed out.
      step(1, 10'b0010101011, 0, 0, 0);
      for (int i = 0; i < 12; i++) step(0, '0, 1, 0, 0);

      // No input after reset: idle symbols and sticky underflow.
      step(0, '0, 0, 0, 1);
      for (int i = 0; i < 16; i++) step(0, '0, 1, 0, 0);
      // Clear during a load with empty buffer: set wins.
      for (int i = 0; i < 5; i++) step(0, '0, 1, (m_idx == 0), 0);
      // Clear while a symbol is held and no load occurs.
      step(1, 10'h155, 0, 0, 0);
      step(0, '0, 0, 1, 0);

      // Continuous stream with incrementing pattern; count in_ready highs.
      step(0, '0, 0, 0, 1);
      pat  = 10'h001;
      nrdy = 0;
      for (int i = 0; i < 60; i++) begin
         step(1, pat, 1, (i == 2), 0);
         if (s_ready) pat = pat + 10'd1;
         if (i >= 10 && s_ready) nrdy++;
      end
      check("ready_rate", nrdy, 32'd10);

      // Reset in the middle of a symbol with the buffer full.
      step(1, 10'h3A5, 1, 0, 0);
      while (m_idx != 3) step(1, 10'h0F0, 1, 0, 0);
      step(1, 10'h0F0, 1, 0, 1);
      for (int i = 0; i < 6; i++) step(0, '0, 1, 0, 0);

      // Randomized traffic, sparse and dense out_en, occasional reset/clear.
      for (int i = 0; i < 2500; i++) begin
         step(($urandom_range(1) == 1),
              10'($urandom),
              (i < 1200) ? ($urandom_range(2) == 0) : ($urandom_range(3) != 0),
              ($urandom_range(9) == 0),
              ($urandom_range(199) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
